// File: rtl/alu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared definitions for the ALU sequencer slice: data/address
//            widths, ALU op codes, sequencer state encoding, flag bit indices
//            and instruction field positions.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int REG_AW = 2;
  localparam int OP_W   = 3;

  // ALU op codes
  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SHR = 3'b001;
  localparam logic [OP_W-1:0] OP_SHL = 3'b010;
  localparam logic [OP_W-1:0] OP_NOT = 3'b011;
  localparam logic [OP_W-1:0] OP_AND = 3'b100;
  localparam logic [OP_W-1:0] OP_OR  = 3'b101;
  localparam logic [OP_W-1:0] OP_XOR = 3'b110;
  localparam logic [OP_W-1:0] OP_CMP = 3'b111;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_EXEC  = 2'b10,
    ST_STORE = 2'b11
  } state_e;

  // Flag register bit positions: {C, A, E, Z}
  localparam int FLAG_C = 3;
  localparam int FLAG_A = 2;
  localparam int FLAG_E = 1;
  localparam int FLAG_Z = 0;

  // Instruction fields
  localparam int INSTR_CLASS = 7;
  localparam int INSTR_OP_HI = 6;
  localparam int INSTR_OP_LO = 4;
  localparam int INSTR_RA_HI = 3;
  localparam int INSTR_RA_LO = 2;
  localparam int INSTR_RB_HI = 1;
  localparam int INSTR_RB_LO = 0;

  // CMP only produces flags; every other op writes its result back.
  function automatic logic op_writes_back(input logic [OP_W-1:0] op);
    return op != OP_CMP;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_regfile.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_regfile
// Purpose  : General register file, NREGS x 8 bits, one synchronous write
//            port and two combinational read ports (operand and debug).
// Ports    : clk, rst         - clock, async active-high reset (clears all)
//            wr_en_i/addr/data - write port
//            op_addr_i/op_data_o   - operand read port
//            dbg_addr_i/dbg_data_o - debug read port
// Revision : 1.0 - initial release
// ============================================================================
module alu_regfile
  import alu_pkg::*;
#(
  parameter int NREGS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [REG_AW-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [REG_AW-1:0] op_addr_i,
  output logic [DATA_W-1:0] op_data_o,
  input  logic [REG_AW-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] regs_q [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign op_data_o  = regs_q[op_addr_i];
  assign dbg_data_o = regs_q[dbg_addr_i];

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Four-state control stage in front of an external combinational
//            8-bit ALU. Accepts one instruction per handshake, loads TMP from
//            R[RA], samples the ALU into ACC/flags, writes ACC back to R[RB].
// Ports    : clk, rst                 - clock, async active-high reset
//            instr_valid/ready/instr  - instruction handshake
//            done, illegal            - one-cycle status pulses
//            alu_a/b/op/carry_in      - ALU operand drive
//            alu_out, alu_A/E/Z/C     - ALU result and flags
//            flags                    - registered {C,A,E,Z}
//            reg_wr_en/addr/data      - external register load (IDLE only)
//            reg_rd_addr/reg_rd_data  - debug register read
// Config   : ALU_CARRY_CHAIN_EN - when defined, alu_carry_in = flags.C;
//            otherwise alu_carry_in is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int NREGS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [7:0]        instr,
  output logic              done,
  output logic              illegal,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_carry_in,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_A,
  input  logic              alu_E,
  input  logic              alu_Z,
  input  logic              alu_C,
  output logic [3:0]        flags,
  input  logic              reg_wr_en,
  input  logic [REG_AW-1:0] reg_wr_addr,
  input  logic [DATA_W-1:0] reg_wr_data,
  input  logic [REG_AW-1:0] reg_rd_addr,
  output logic [DATA_W-1:0] reg_rd_data
);

  state_e            state_q,   state_d;
  logic [OP_W-1:0]   op_q,      op_d;
  logic [REG_AW-1:0] ra_q,      ra_d;
  logic [REG_AW-1:0] rb_q,      rb_d;
  logic [DATA_W-1:0] tmp_q,     tmp_d;
  logic [DATA_W-1:0] acc_q,     acc_d;
  logic [3:0]        flags_q,   flags_d;
  logic              done_q,    done_d;
  logic              illegal_q, illegal_d;

  logic              w_rf_wr_en;
  logic [REG_AW-1:0] w_rf_wr_addr;
  logic [DATA_W-1:0] w_rf_wr_data;
  logic [REG_AW-1:0] w_opnd_addr;
  logic [DATA_W-1:0] w_opnd_data;

  // The single operand port serves R[RA] while loading TMP and R[RB]
  // everywhere else; the ALU is only sampled in EXEC, where it sees R[RB].
  assign w_opnd_addr = (state_q == ST_LOAD) ? ra_q : rb_q;

  alu_regfile #(
    .NREGS (NREGS)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (w_rf_wr_en),
    .wr_addr_i  (w_rf_wr_addr),
    .wr_data_i  (w_rf_wr_data),
    .op_addr_i  (w_opnd_addr),
    .op_data_o  (w_opnd_data),
    .dbg_addr_i (reg_rd_addr),
    .dbg_data_o (reg_rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      tmp_q     <= '0;
      acc_q     <= '0;
      flags_q   <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      tmp_q     <= tmp_d;
      acc_q     <= acc_d;
      flags_q   <= flags_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    ra_d         = ra_q;
    rb_d         = rb_q;
    tmp_d        = tmp_q;
    acc_d        = acc_q;
    flags_d      = flags_q;
    done_d       = 1'b0;
    illegal_d    = 1'b0;
    w_rf_wr_en   = 1'b0;
    w_rf_wr_addr = reg_wr_addr;
    w_rf_wr_data = reg_wr_data;

    case (state_q)
      ST_IDLE: begin
        // External loads land on the accept edge, so LOAD already sees them.
        w_rf_wr_en = reg_wr_en;
        if (instr_valid) begin
          op_d = instr[INSTR_OP_HI:INSTR_OP_LO];
          ra_d = instr[INSTR_RA_HI:INSTR_RA_LO];
          rb_d = instr[INSTR_RB_HI:INSTR_RB_LO];
          if (instr[INSTR_CLASS]) begin
            state_d = ST_LOAD;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        tmp_d   = w_opnd_data;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        acc_d           = alu_out;
        flags_d[FLAG_C] = alu_C;
        flags_d[FLAG_A] = alu_A;
        flags_d[FLAG_E] = alu_E;
        flags_d[FLAG_Z] = alu_Z;
        state_d         = ST_STORE;
      end
      ST_STORE: begin
        if (op_writes_back(op_q)) begin
          w_rf_wr_en   = 1'b1;
          w_rf_wr_addr = rb_q;
          w_rf_wr_data = acc_q;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef ALU_CARRY_CHAIN_EN
  assign alu_carry_in = flags_q[FLAG_C];
`else
  assign alu_carry_in = 1'b0;
`endif

  assign instr_ready = (state_q == ST_IDLE);
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign flags       = flags_q;
  assign alu_a       = w_opnd_data;
  assign alu_b       = tmp_q;
  assign alu_op      = op_q;

endmodule
`default_nettype wire
